// File: rtl/sram_accum_pkg.sv
// sram_accum_pkg: shared FSM encoding and saturation-mode constants
package sram_accum_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;
  localparam bit SAT_WRAP = 1'b0;
  localparam bit SAT_SAT  = 1'b1;
endpackage

// File: rtl/sram_accum_sdp.sv
// sram_sdp: simple dual-port RAM, one write port, one registered read port, no reset
module sram_sdp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  assign rdata_o = rdata_q;
  // write port and one-cycle registered read port
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end
endmodule

// File: rtl/sram_accum.sv
// sram_accum: loads words into an SRAM, then sums len of them top-down with wrap or saturate
module sram_accum
  import sram_accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int DEPTH  = 512,
  parameter bit SAT    = SAT_WRAP,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow
);
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d, ptr_init;
  logic [ADDR_W:0]    len_c;
  logic               rd_valid_q;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_add, sum_q, sum_d;
  logic [ACC_W:0]     add_w;
  logic               ovf_q, ovf_d, overflow_q, overflow_d;
  logic               carry, start_ok, rd_en, we;
  logic [DATA_W-1:0]  rd_data;

  sram_sdp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (ptr_q),
    .rdata_o (rd_data)
  );

  assign sum      = sum_q;
  assign overflow = overflow_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state: a zero-length pass skips straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? ((len == '0) ? S_DONE : S_READ) : S_IDLE;
      S_READ:  state_d = (ptr_q == '0) ? S_DRAIN : S_READ;
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; writes are only honoured while idle so a pass sees a stable image
  always_comb begin
    busy      = state_q != S_IDLE;
    sum_valid = state_q == S_DONE;
    rd_en     = state_q == S_READ;
    we        = wr_en && state_q == S_IDLE;
    start_ok  = start && state_q == S_IDLE;
  end

  // datapath next-state: clamp len, walk pointer down, accumulate with carry detect
  always_comb begin
    len_c      = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
    ptr_init   = ADDR_W'(len_c - 1'b1);
    add_w      = {1'b0, acc_q} + (ACC_W+1)'(rd_data);
    carry      = add_w[ACC_W];
    acc_add    = (SAT == SAT_SAT && carry) ? '1 : add_w[ACC_W-1:0];
    ptr_d      = start_ok ? ptr_init : (rd_en && ptr_q != '0) ? ptr_q - 1'b1 : ptr_q;
    acc_d      = start_ok ? '0 : rd_valid_q ? acc_add : acc_q;
    ovf_d      = start_ok ? 1'b0 : (rd_valid_q && carry) ? 1'b1 : ovf_q;
    sum_d      = start_ok ? '0 : (state_q == S_DRAIN) ? acc_d : sum_q;
    overflow_d = start_ok ? 1'b0 : (state_q == S_DRAIN) ? ovf_d : overflow_q;
  end

  // datapath registers; the result is published on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_en;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_sram_accum.sv
// tb_sram_accum: directed self-checking bench for sram_accum
module tb_sram_accum;
  localparam int AW = 9;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [AW:0]   len = '0;
  logic busy, sum_valid, overflow;
  logic [39:0] sum;
  logic busy_w, sv_w, ovf_w, busy_s, sv_s, ovf_s;
  logic [32:0] sum_w, sum_s;
  int n_cmp = 0, n_err = 0;
  int vcyc, nvalid, bfirst, blast, rdcnt;

  always #5 clk = ~clk;

  sram_accum dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .busy(busy), .sum_valid(sum_valid), .sum(sum), .overflow(overflow)
  );
  sram_accum #(.DATA_W(32), .ACC_W(33), .DEPTH(16), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
    .start(start), .len(len[4:0]), .busy(busy_w), .sum_valid(sv_w), .sum(sum_w), .overflow(ovf_w)
  );
  sram_accum #(.DATA_W(32), .ACC_W(33), .DEPTH(16), .SAT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
    .start(start), .len(len[4:0]), .busy(busy_s), .sum_valid(sv_s), .sum(sum_s), .overflow(ovf_s)
  );

  task automatic write_word(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // cycle 0 is the cycle start is high; outputs sampled on the falling edge
  task automatic run_pass(input int l, input int ncyc, input int st_cyc, input int wr_cyc);
    vcyc = -1; nvalid = 0; bfirst = -1; blast = -1; rdcnt = 0;
    @(posedge clk); #1;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == st_cyc);
      len   = l[AW:0];
      wr_en = (c == wr_cyc);
      @(negedge clk);
      if (sum_valid) begin nvalid++; if (vcyc < 0) vcyc = c; end
      if (busy) begin if (bfirst < 0) bfirst = c; blast = c; end
      if (dut.rd_en) rdcnt++;
      @(posedge clk); #1;
    end
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", sum_valid); end
    n_cmp++; if (sum !== 40'd0) begin n_err++; $display("FAIL rst_sum got %h want 0", sum); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 10; i++) write_word(i, 32'(i + 1));
    run_pass(10, 16, -1, -1);
    n_cmp++; if (vcyc !== 12) begin n_err++; $display("FAIL basic_vcyc got %0d want 12", vcyc); end
    n_cmp++; if (nvalid !== 1) begin n_err++; $display("FAIL basic_nvalid got %0d want 1", nvalid); end
    n_cmp++; if (bfirst !== 1 || blast !== 12) begin n_err++; $display("FAIL basic_busy got %0d..%0d want 1..12", bfirst, blast); end
    n_cmp++; if (sum !== 40'd55) begin n_err++; $display("FAIL basic_sum got %0d want 55", sum); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b want 0", overflow); end
    n_cmp++; if (rdcnt !== 10) begin n_err++; $display("FAIL basic_reads got %0d want 10", rdcnt); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 3; i++) write_word(i, 32'hFFFF_FFFF);
    run_pass(3, 8, -1, -1);
    n_cmp++; if (sum_w !== 33'h0_FFFF_FFFD) begin n_err++; $display("FAIL wrap_sum got %h want 0fffffffd", sum_w); end
    n_cmp++; if (ovf_w !== 1'b1) begin n_err++; $display("FAIL wrap_ovf got %b want 1", ovf_w); end
    n_cmp++; if (sum_s !== 33'h1_FFFF_FFFF) begin n_err++; $display("FAIL sat_sum got %h want 1ffffffff", sum_s); end
    n_cmp++; if (ovf_s !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", ovf_s); end
    n_cmp++; if (sum !== 40'h2_FFFF_FFFD) begin n_err++; $display("FAIL wide_sum got %h want 2fffffffd", sum); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wide_ovf got %b want 0", overflow); end
    n_cmp++; if (vcyc !== 5) begin n_err++; $display("FAIL wide_vcyc got %0d want 5", vcyc); end
  endtask

  task automatic test_len_zero;
    run_pass(0, 4, -1, -1);
    n_cmp++; if (vcyc !== 1) begin n_err++; $display("FAIL zero_vcyc got %0d want 1", vcyc); end
    n_cmp++; if (nvalid !== 1) begin n_err++; $display("FAIL zero_nvalid got %0d want 1", nvalid); end
    n_cmp++; if (sum !== 40'd0) begin n_err++; $display("FAIL zero_sum got %0d want 0", sum); end
    n_cmp++; if (rdcnt !== 0) begin n_err++; $display("FAIL zero_reads got %0d want 0", rdcnt); end
    n_cmp++; if (ovf_w !== 1'b0 || sum_w !== 33'd0) begin n_err++; $display("FAIL zero_clear got ovf=%b sum=%h want 0/0", ovf_w, sum_w); end
  endtask

  task automatic test_len_clamp;
    for (int i = 0; i < 512; i++) write_word(i, 32'(i + 1));
    run_pass(517, 520, -1, -1);
    n_cmp++; if (sum !== 40'd131328) begin n_err++; $display("FAIL clamp_sum got %0d want 131328", sum); end
    n_cmp++; if (vcyc !== 514) begin n_err++; $display("FAIL clamp_vcyc got %0d want 514", vcyc); end
    n_cmp++; if (rdcnt !== 512) begin n_err++; $display("FAIL clamp_reads got %0d want 512", rdcnt); end
  endtask

  task automatic test_back_to_back;
    wr_addr = 9'd3; wr_data = 32'd1000;
    run_pass(8, 14, 3, 5);
    n_cmp++; if (nvalid !== 1) begin n_err++; $display("FAIL busy_start_nvalid got %0d want 1", nvalid); end
    n_cmp++; if (vcyc !== 10) begin n_err++; $display("FAIL busy_start_vcyc got %0d want 10", vcyc); end
    n_cmp++; if (sum !== 40'd36) begin n_err++; $display("FAIL busy_write_sum got %0d want 36", sum); end
    run_pass(8, 12, -1, -1);
    n_cmp++; if (sum !== 40'd36) begin n_err++; $display("FAIL dropped_write_sum got %0d want 36", sum); end
  endtask

  task automatic test_reset_mid;
    int nv;
    @(posedge clk); #1;
    start = 1'b1; len = 10'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (sum_valid !== 1'b0 || sum !== 40'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL mid_outs got v=%b s=%0d o=%b want 0", sum_valid, sum, overflow); end
    nv = 0;
    repeat (4) @(negedge clk) if (sum_valid) nv++;
    rst_n = 1'b1;
    repeat (12) @(negedge clk) if (sum_valid) nv++;
    n_cmp++; if (nv !== 0) begin n_err++; $display("FAIL mid_novalid got %0d want 0", nv); end
    run_pass(4, 8, -1, -1);
    n_cmp++; if (sum !== 40'd10) begin n_err++; $display("FAIL mid_after_sum got %0d want 10", sum); end
    n_cmp++; if (vcyc !== 6) begin n_err++; $display("FAIL mid_after_vcyc got %0d want 6", vcyc); end
  endtask

  task automatic test_same_cycle;
    wr_addr = '0; wr_data = 32'd100;
    run_pass(1, 6, -1, 0);
    n_cmp++; if (sum !== 40'd100) begin n_err++; $display("FAIL same_sum got %0d want 100", sum); end
    n_cmp++; if (vcyc !== 3) begin n_err++; $display("FAIL same_vcyc got %0d want 3", vcyc); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_len_zero;
    test_len_clamp;
    test_back_to_back;
    test_reset_mid;
    test_same_cycle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
